// File: rtl/apb_pkg.sv
// Shared APB types: transfer state, bus widths, default ID word and
// error-cause encodings used by the responder and the bridge bench.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   localparam logic [31:0] APB_ID_DEFAULT = 32'hA5B0_0001;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS
   } apb_state_e;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_MISS,
      ERR_ALIGN,
      ERR_RO
   } apb_err_e;

endpackage

// File: rtl/apb_slave_decode.sv
// Address decode for one APB slot: word index, slot hit and access error.
// Pure combinational so the bridge select decode can be checked against it.
module apb_slave_decode
   import apb_pkg::*;
#(
   parameter int          NUM_REGS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   localparam int         IDX_W     = $clog2(NUM_REGS)
) (
   input  logic [APB_ADDR_W-1:0] paddr,
   input  logic                  pwrite,
   output logic                  hit,
   output logic [IDX_W-1:0]      idx,
   output logic                  err
);

   apb_err_e cause;

   always_comb begin
      idx   = paddr[IDX_W+1:2];
      hit   = paddr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2];
      cause = ERR_NONE;
      if (!hit)
         cause = ERR_MISS;
      else if (paddr[1:0] != 2'b00)
         cause = ERR_ALIGN;
      else if (pwrite && idx == '0)
         cause = ERR_RO;
      err = cause != ERR_NONE;
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder with a read-only ID word and NUM_REGS-1 RW words.
// Optional byte strobes enabled by defining APB_SLAVE_PSTRB_EN.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int          NUM_REGS    = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = APB_ID_DEFAULT
) (
   input  logic                     hclk,
   input  logic                     hreset,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [APB_ADDR_W-1:0]    paddr,
   input  logic [APB_DATA_W-1:0]    pwdata,
`ifdef APB_SLAVE_PSTRB_EN
   input  logic [3:0]               pstrb,
`endif
   output logic [APB_DATA_W-1:0]    prdata,
   output logic                     pready,
   output logic                     pslverr,
   output logic [NUM_REGS*32-1:0]   regs_out
);

   localparam int IDX_W = $clog2(NUM_REGS);

   apb_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wr_q, wr_d;
   logic             err_q, err_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             pready_q, pready_d;
   logic             pslverr_q, pslverr_d;
   logic [31:0]      prdata_q, prdata_d;
   logic [31:0]      regs_q [NUM_REGS];
   logic [31:0]      regs_d [NUM_REGS];

   logic             dec_hit;
   logic [IDX_W-1:0] dec_idx;
   logic             dec_err;
   logic             err_now;
   logic [31:0]      rd_now;
   logic [31:0]      rd_lat;
   logic [3:0]       strb;

   apb_slave_decode #(
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE_ADDR)
   ) u_dec (
      .paddr  (paddr),
      .pwrite (pwrite),
      .hit    (dec_hit),
      .idx    (dec_idx),
      .err    (dec_err)
   );

`ifdef APB_SLAVE_PSTRB_EN
   assign strb = pstrb;
`else
   assign strb = 4'hF;
`endif

   assign err_now = dec_err | ~dec_hit;
   assign rd_now  = err_now ? '0 :
                    (dec_idx == '0) ? ID_VALUE : regs_q[dec_idx];
   assign rd_lat  = err_q ? '0 :
                    (idx_q == '0) ? ID_VALUE : regs_q[idx_q];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_d      = wr_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      regs_d    = regs_q;
      unique case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               idx_d = dec_idx;
               wr_d  = pwrite;
               err_d = err_now;
               if (WAIT_STATES == 0) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_now;
                  prdata_d  = rd_now;
                  state_d   = ACCESS;
               end else begin
                  cnt_d    = 4'(WAIT_STATES);
                  pready_d = 1'b0;
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            if (!psel) begin
               pready_d = 1'b0;
               state_d  = IDLE;
            end else if (penable) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = rd_lat;
                  state_d   = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!psel) begin
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               state_d   = IDLE;
            end else if (penable) begin
               // Only an error-free write commits; strobes pick the bytes.
               if (wr_q && !err_q) begin
                  for (int b = 0; b < 4; b++) begin
                     if (strb[b])
                        regs_d[idx_q][8*b +: 8] = pwdata[8*b +: 8];
                  end
               end
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         regs_q    <= regs_d;
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

   always_comb begin
      regs_out = '0;
      for (int i = 0; i < NUM_REGS; i++)
         regs_out[32*i +: 32] = (i == 0) ? ID_VALUE : regs_q[i];
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile: a zero-wait and a 3-wait slot
// driven by an APB task and checked against an array reference model.
module tb_apb_slave_regfile;

   localparam int          NR    = 8;
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h4000_0100;
   localparam logic [31:0] IDV   = 32'hA5B0_0001;

   logic              clk = 1'b0;
   logic              hreset;
   logic [1:0]        psel;
   logic [1:0]        penable;
   logic [1:0]        pwrite;
   logic [1:0][31:0]  paddr;
   logic [1:0][31:0]  pwdata;
`ifdef APB_SLAVE_PSTRB_EN
   logic [1:0][3:0]   pstrb;
`endif
   logic [31:0]       prdata0, prdata1;
   logic              pready0, pready1;
   logic              pslverr0, pslverr1;
   logic [NR*32-1:0]  regs0, regs1;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl [2][NR];

   always #5 clk = ~clk;

   apb_slave_regfile #(
      .NUM_REGS(NR), .BASE_ADDR(BASE0), .WAIT_STATES(0), .ID_VALUE(IDV)
   ) dut0 (
      .hclk(clk), .hreset(hreset), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_SLAVE_PSTRB_EN
      .pstrb(pstrb[0]),
`endif
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
      .regs_out(regs0)
   );

   apb_slave_regfile #(
      .NUM_REGS(NR), .BASE_ADDR(BASE1), .WAIT_STATES(3), .ID_VALUE(IDV)
   ) dut1 (
      .hclk(clk), .hreset(hreset), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_SLAVE_PSTRB_EN
      .pstrb(pstrb[1]),
`endif
      .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
      .regs_out(regs1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] base(input int d);
      return (d == 0) ? BASE0 : BASE1;
   endfunction

   function automatic int ws(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? pready0 : pready1;
   endfunction

   function automatic logic serr(input int d);
      return (d == 0) ? pslverr0 : pslverr1;
   endfunction

   function automatic logic [31:0] rdat(input int d);
      return (d == 0) ? prdata0 : prdata1;
   endfunction

   function automatic logic [31:0] img(input int d, input int i);
      return (d == 0) ? regs0[32*i +: 32] : regs1[32*i +: 32];
   endfunction

   function automatic bit bad(input int d, input bit wr,
                              input logic [31:0] a);
      bit inr;
      inr = (a >= base(d)) && (a < base(d) + NR * 4);
      return !inr || (a % 4 != 0) || (wr && (a - base(d)) < 4);
   endfunction

   function automatic logic [31:0] exp_rd(input int d, input logic [31:0] a);
      int w;
      if (bad(d, 1'b0, a)) return '0;
      w = int'((a - base(d)) / 4);
      return (w == 0) ? IDV : mdl[d][w];
   endfunction

   function automatic logic [3:0] eff_strb(input logic [3:0] st);
`ifdef APB_SLAVE_PSTRB_EN
      return st;
`else
      return 4'hF;
`endif
   endfunction

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NR; i++)
            mdl[d][i] = '0;
   endtask

   task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input string tag, output logic [31:0] rd);
      int waits;
      bit eb;
      logic [31:0 ] er;
      @(negedge clk);
      psel[1-d]    = 1'b0;
      penable[1-d] = 1'b0;
      psel[d]      = 1'b1;
      penable[d]   = 1'b0;
      pwrite[d]    = wr;
      paddr[d]     = a;
      pwdata[d]    = wd;
`ifdef APB_SLAVE_PSTRB_EN
      pstrb[d]     = st;
`endif
      eb = bad(d, wr, a);
      er = exp_rd(d, a);
      @(negedge clk);
      penable[d] = 1'b1;
      waits = 0;
      while (!rdy(d) && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      chk({tag, "_rdy"}, 32'(rdy(d)), 32'd1);
      chk({tag, "_wait"}, 32'(waits), 32'(ws(d)));
      chk({tag, "_err"}, 32'(serr(d)), 32'(eb));
      rd = rdat(d);
      if (!wr) chk({tag, "_rdata"}, rd, er);
      if (wr && !eb) begin
         for (int b = 0; b < 4; b++)
            if (eff_strb(st)[b])
               mdl[d][(a - base(d)) / 4][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      chk("idle_rdy", 32'(rdy(d)), 32'd0);
      chk("idle_err", 32'(serr(d)), 32'd0);
   endtask

   task automatic chk_image(input string tag);
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NR; i++)
            chk(tag, img(d, i), (i == 0) ? IDV : mdl[d][i]);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      int d;
      int r;
      psel    = '0;
      penable = '0;
      pwrite  = '0;
      paddr   = '0;
      pwdata  = '0;
`ifdef APB_SLAVE_PSTRB_EN
      pstrb   = '0;
`endif
      clear_model();
      hreset = 1'b1;
      repeat (3) @(negedge clk);
      hreset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("rst_rdy", 32'(rdy(k)), 32'd0);
         chk("rst_err", 32'(serr(k)), 32'd0);
         chk("rst_rdata", rdat(k), 32'd0);
      end
      chk_image("rst_img");

      xfer(0, 1'b0, BASE0 + 32'h04, 32'd0, 4'hF, "rd04", rd);
      xfer(0, 1'b1, BASE0 + 32'h08, 32'hDEAD_BEEF, 4'hF, "wr08", rd);
      xfer(0, 1'b0, BASE0 + 32'h08, 32'd0, 4'hF, "rd08", rd);
      chk("rd08_val", rd, 32'hDEAD_BEEF);
      idle(0);
      @(negedge clk);
      chk("img08", regs0[95:64], 32'hDEAD_BEEF);

      xfer(1, 1'b0, BASE1, 32'd0, 4'hF, "rdid", rd);
      chk("rdid_val", rd, IDV);
      idle(1);

      for (int k = 0; k < 2; k++) begin
         xfer(k, 1'b1, base(k), 32'h1234_5678, 4'hF, "wr_ro", rd);
         xfer(k, 1'b1, base(k) + 32'h22, 32'h1234_5678, 4'hF, "wr_ua", rd);
         xfer(k, 1'b0, base(k) + NR * 4, 32'd0, 4'hF, "rd_oob", rd);
         chk("rd_oob_val", rd, 32'd0);
         idle(k);
      end
      chk_image("err_img");

      xfer(0, 1'b1, BASE0 + 32'h0C, 32'd1, 4'hF, "b2b_wr", rd);
      xfer(0, 1'b0, BASE0 + 32'h0C, 32'd0, 4'hF, "b2b_rd", rd);
      chk("b2b_val", rd, 32'd1);
      idle(0);

`ifdef APB_SLAVE_PSTRB_EN
      xfer(0, 1'b1, BASE0 + 32'h14, 32'hFFFF_FFFF, 4'hF, "st_full", rd);
      xfer(0, 1'b1, BASE0 + 32'h14, 32'h1122_3344, 4'b0101, "st_part", rd);
      xfer(0, 1'b1, BASE0 + 32'h14, 32'h0000_0000, 4'b0000, "st_none", rd);
      xfer(0, 1'b0, BASE0 + 32'h14, 32'd0, 4'hF, "st_rd", rd);
      chk("st_val", rd, 32'hFF22_FF44);
      idle(0);
`endif

      @(negedge clk);
      psel[1]    = 1'b1;
      penable[1] = 1'b0;
      pwrite[1]  = 1'b1;
      paddr[1]   = BASE1 + 32'h10;
      pwdata[1]  = 32'hCAFE_F00D;
      @(negedge clk);
      penable[1] = 1'b1;
      @(negedge clk);
      chk("rstw_rdy0", 32'(pready1), 32'd0);
      hreset = 1'b1;
      @(negedge clk);
      hreset     = 1'b0;
      psel[1]    = 1'b0;
      penable[1] = 1'b0;
      chk("rstw_rdy", 32'(pready1), 32'd0);
      clear_model();
      xfer(1, 1'b0, BASE1 + 32'h10, 32'd0, 4'hF, "rstw_rd", rd);
      chk("rstw_val", rd, 32'd0);
      idle(1);

      for (int n = 0; n < 60; n++) begin
         d = int'($urandom_range(1, 0));
         r = int'($urandom_range(7, 0));
         if (r < 6)
            a = base(d) + 32'($urandom_range(NR - 1, 0)) * 4;
         else if (r == 6)
            a = base(d) + 32'($urandom_range(NR * 4 - 1, 0));
         else
            a = base(d) + NR * 4 + 32'($urandom_range(15, 0)) * 4;
         xfer(d, 1'($urandom_range(1, 0)), a, $urandom,
              4'($urandom_range(15, 0)), "rnd", rd);
         if ($urandom_range(2, 0) == 0) idle(d);
      end
      idle(0);
      idle(1);
      @(negedge clk);
      chk_image("end_img");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
